// File: rtl/fetch_pc_gen_pkg.sv
// Shared bus widths, reset vector and fetch FSM encoding for the IF-stage PC generator.
package fetch_pc_gen_pkg;

  localparam int unsigned ADDR_BUS = 32;
  localparam int unsigned DATA_BUS = 32;
  localparam int unsigned INST_BUS = 32;

  localparam logic [ADDR_BUS-1:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// IF-stage PC generator: drives the imem request handshake, applies branch/exception redirects
// and buffers a fetched word across pipeline stalls so nothing is lost or delivered twice.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned          ADDR_W   = ADDR_BUS,
  parameter int unsigned          DATA_W   = INST_BUS,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              exc_flag,
  input  logic [ADDR_W-1:0] exc_pc,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ready,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              fetch_stall
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic              done;
  logic [ADDR_W-1:0] next_pc;

  assign done      = inst_req & inst_ready;
  // The redirect is taken on the advance that retires the delay-slot word.
  assign next_pc   = branch_flag ? branch_addr : pc_q + ADDR_W'(4);
  assign inst_addr = pc_q;
  assign if_pc     = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    buf_d        = buf_q;
    inst_req     = 1'b0;
    if_valid     = 1'b0;
    if_inst      = '0;
    fetch_stall  = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        inst_req = 1'b1;
        if (inst_ready) begin
          if (exc_flag) begin
            pc_d = exc_pc;
          end else if (!stall) begin
            if_valid = 1'b1;
            if_inst  = inst_rdata;
            pc_d     = next_pc;
          end else begin
            buf_d   = inst_rdata;
            state_d = S_HOLD;
          end
        end else begin
          fetch_stall = 1'b1;
          if (exc_flag) begin
            pend_addr_d  = exc_pc;
            pend_valid_d = 1'b1;
            state_d      = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        // The outstanding request cannot be withdrawn; its data is discarded on completion.
        inst_req    = 1'b1;
        fetch_stall = 1'b1;
        if (exc_flag) begin
          pend_addr_d = exc_pc;
        end
        if (inst_ready) begin
          pc_d         = exc_flag ? exc_pc : pend_addr_q;
          pend_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end

      S_HOLD: begin
        if (exc_flag) begin
          pc_d    = exc_pc;
          state_d = S_FETCH;
        end else if (!stall) begin
          if_valid = 1'b1;
          if_inst  = buf_q;
          pc_d     = next_pc;
          state_d  = S_FETCH;
        end
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      pc_q         <= RESET_PC;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      buf_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      buf_q        <= buf_d;
    end
  end

endmodule
